// File: rtl/controle_temporizador.sv
// Run controller for an external 4-bit synchronous up-counter: R ticks of P cycles each.
// Optional CONTROLE_TEMPORIZADOR_PAUSA_EN adds a pausar input that freezes counting.
module controle_temporizador (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] periodo,
  input  logic [3:0] repeticoes,
  input  logic       cnt_rco,
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
  input  logic       pausar,
`endif
  output logic       cnt_clr_n,
  output logic       cnt_ld_n,
  output logic       cnt_enp,
  output logic       cnt_ent,
  output logic [3:0] cnt_d,
  output logic       tick,
  output logic       ocupado,
  output logic       pronto,
  output logic       abortado,
  output logic [4:0] restantes,
  output logic [2:0] estado
);

  localparam int unsigned RW = 5;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CARREGA = 3'd1;
  localparam logic [2:0] CONTA   = 3'd2;
  localparam logic [2:0] FIM     = 3'd3;
  localparam logic [2:0] ABORTA  = 3'd4;

  logic [2:0]    estado_q, estado_d;
  logic [3:0]    p_q;
  logic [RW-1:0] rest_q, rest_d;
  logic          pausa_c;
  logic          rco_c;
  logic          carrega_c;

`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
  assign pausa_c = pausar;
`else
  assign pausa_c = 1'b0;
`endif

  // Carry only counts while actively counting and not frozen
  assign rco_c     = cnt_rco & (estado_q == CONTA) & ~pausa_c;
  assign carrega_c = (estado_q == IDLE) & iniciar;

  // Load value makes the counter wrap to 15 after exactly P counts; P=0 means 16
  assign cnt_d     = 4'(5'd16 - {1'b0, p_q});
  assign restantes = rest_q;
  assign estado    = estado_q;

  // State, latched period and remaining-tick register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      estado_q <= IDLE;
      p_q      <= 4'd0;
      rest_q   <= '0;
    end else begin
      estado_q <= estado_d;
      rest_q   <= rest_d;
      if (carrega_c) p_q <= periodo;
    end
  end

  // Next state and decoded counter controls
  always_comb begin
    estado_d  = estado_q;
    rest_d    = rest_q;
    tick      = 1'b0;
    ocupado   = 1'b0;
    pronto    = 1'b0;
    abortado  = 1'b0;
    cnt_clr_n = 1'b1;
    cnt_ld_n  = 1'b1;
    cnt_enp   = 1'b0;
    cnt_ent   = 1'b0;
    case (estado_q)
      IDLE: begin
        if (iniciar) begin
          estado_d = CARREGA;
          rest_d   = (repeticoes == 4'd0) ? RW'(16) : {1'b0, repeticoes};
        end
      end
      CARREGA: begin
        ocupado  = 1'b1;
        cnt_ld_n = 1'b0;
        if (parar) begin
          estado_d = ABORTA;
          rest_d   = '0;
        end else begin
          estado_d = CONTA;
        end
      end
      CONTA: begin
        ocupado = 1'b1;
        cnt_enp = ~pausa_c;
        cnt_ent = ~pausa_c;
        if (parar) begin
          estado_d = ABORTA;
          rest_d   = '0;
        end else if (rco_c) begin
          tick   = 1'b1;
          rest_d = rest_q - RW'(1);
          // Reload on the wrap cycle so consecutive periods have no gap
          if (rest_q > RW'(1)) cnt_ld_n = 1'b0;
          else                 estado_d = FIM;
        end
      end
      FIM: begin
        cnt_clr_n = 1'b0;
        pronto    = 1'b1;
        estado_d  = IDLE;
      end
      ABORTA: begin
        cnt_clr_n = 1'b0;
        abortado  = 1'b1;
        estado_d  = IDLE;
      end
      default: estado_d = IDLE;
    endcase
    if (RESET) begin
      tick      = 1'b0;
      ocupado   = 1'b0;
      pronto    = 1'b0;
      abortado  = 1'b0;
      cnt_clr_n = 1'b0;
      cnt_ld_n  = 1'b1;
      cnt_enp   = 1'b0;
      cnt_ent   = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_temporizador.sv
// Bench for controle_temporizador with a behavioural 4-bit counter and an event scoreboard.
module tb_controle_temporizador;

  logic       CLK;
  logic       RESET;
  logic       iniciar, parar;
  logic [3:0] periodo, repeticoes;
  logic       cnt_rco;
  logic       cnt_clr_n, cnt_ld_n, cnt_enp, cnt_ent;
  logic [3:0] cnt_d;
  logic       tick, ocupado, pronto, abortado;
  logic [4:0] restantes;
  logic [2:0] estado;
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
  logic       pausar;
`endif

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {abortado, pronto, tick}
    logic [4:0] rest;
  } ev_t;

  ev_t  sb[$];
  logic ld_log[$];
  int   clr_low;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [3:0] q;

  controle_temporizador dut (
    .CLK(CLK), .RESET(RESET), .iniciar(iniciar), .parar(parar),
    .periodo(periodo), .repeticoes(repeticoes), .cnt_rco(cnt_rco),
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
    .pausar(pausar),
`endif
    .cnt_clr_n(cnt_clr_n), .cnt_ld_n(cnt_ld_n), .cnt_enp(cnt_enp), .cnt_ent(cnt_ent),
    .cnt_d(cnt_d), .tick(tick), .ocupado(ocupado), .pronto(pronto),
    .abortado(abortado), .restantes(restantes), .estado(estado)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // External counter: clear > load > count, RCO = ENT & Q==15
  always @(posedge CLK) begin
    if (!cnt_clr_n)              q <= 4'd0;
    else if (!cnt_ld_n)          q <= cnt_d;
    else if (cnt_enp && cnt_ent) q <= q + 4'd1;
  end
  assign cnt_rco = cnt_ent & (q == 4'd15);

  task automatic push_run(input int c0, input int p, input int r);
    ev_t e;
    for (int k = 1; k <= r; k++) begin
      e.cyc = c0 + k * p; e.kind = 3'b001; e.rest = 5'(r - k + 1);
      sb.push_back(e);
    end
    e.cyc = c0 + p * r + 1; e.kind = 3'b010; e.rest = 5'd0;
    sb.push_back(e);
  endtask

  // Pops one expectation per observed event; logs cnt_ld_n on ticks and counts clear cycles
  task automatic sb_drain(input int max_cyc, input bit stop_empty);
    ev_t e;
    logic [2:0] k;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (cnt_clr_n === 1'b0) clr_low++;
      k = {abortado, pronto, tick};
      if (k !== 3'b000) begin
        if (tick === 1'b1) ld_log.push_back(cnt_ld_n);
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_event kind=%b cyc=%0d required none", k, cyc);
        end else begin
          e = sb.pop_front();
          if (k !== e.kind || cyc !== e.cyc || restantes !== e.rest)
            $display("FAIL event got kind=%b cyc=%0d rest=%0d required kind=%b cyc=%0d rest=%0d",
                     k, cyc, restantes, e.kind, e.cyc, e.rest);
          else n_pass++;
        end
      end
      if (stop_empty && sb.size() == 0) break;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; iniciar = 1'b0; parar = 1'b0; periodo = 4'd0; repeticoes = 4'd0;
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
    pausar = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({estado, restantes, cnt_d} !== {3'd0, 5'd0, 4'd0})
      $display("FAIL reset_state got estado=%0d rest=%0d d=%0d required 0 0 0", estado, restantes, cnt_d);
    else n_pass++;
    n_checks++;
    if ({cnt_clr_n, cnt_ld_n, cnt_enp, cnt_ent, tick, ocupado, pronto, abortado} !== 8'b0100_0000)
      $display("FAIL reset_outputs got %b required 01000000",
               {cnt_clr_n, cnt_ld_n, cnt_enp, cnt_ent, tick, ocupado, pronto, abortado});
    else n_pass++;
    RESET = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({estado, cnt_clr_n, cnt_ld_n} !== {3'd0, 2'b11})
      $display("FAIL idle_after_reset got estado=%0d clr=%b ld=%b required 0 1 1", estado, cnt_clr_n, cnt_ld_n);
    else n_pass++;
    // parar in IDLE does nothing
    parar = 1'b1;
    sb_drain(3, 1'b0);
    parar = 1'b0;
    n_checks++;
    if (estado !== 3'd0) $display("FAIL parar_idle got estado=%0d required 0", estado);
    else n_pass++;
  endtask

  task automatic test_normal(input int p, input int r, input logic [3:0] exp_d);
    int c0;
    logic [2:0] lds;
    periodo = 4'(p); repeticoes = 4'(r);
    @(negedge CLK); iniciar = 1'b1; c0 = cyc + 1;
    push_run(c0, (p == 0) ? 16 : p, (r == 0) ? 16 : r);
    @(negedge CLK); iniciar = 1'b0;
    n_checks++;
    if ({estado, cnt_ld_n, ocupado, cnt_d, restantes} !== {3'd1, 1'b0, 1'b1, exp_d, 5'(r)})
      $display("FAIL carrega_p%0d got estado=%0d ld=%b oc=%b d=%0d rest=%0d required 1 0 1 %0d %0d",
               p, estado, cnt_ld_n, ocupado, cnt_d, restantes, exp_d, r);
    else n_pass++;
    ld_log.delete(); clr_low = 0;
    sb_drain(60, 1'b1);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL missing_events_p%0d got %0d pending required 0", p, sb.size());
    else n_pass++;
    lds = 3'b111;
    for (int i = 0; i < ld_log.size() && i < 3; i++) lds[2 - i] = ld_log[i];
    if (r == 3) begin
      n_checks++;
      if (lds !== 3'b001) $display("FAIL ld_on_ticks_p%0d got %b required 001", p, lds);
      else n_pass++;
    end else if (r == 2) begin
      n_checks++;
      if (lds[2:1] !== 2'b01) $display("FAIL ld_on_ticks_p%0d got %b required 01", p, lds[2:1]);
      else n_pass++;
    end
    @(negedge CLK);
    n_checks++;
    if ({estado, restantes, clr_low} !== {3'd0, 5'd0, 32'd1})
      $display("FAIL end_idle_p%0d got estado=%0d rest=%0d clr_low=%0d required 0 0 1",
               p, estado, restantes, clr_low);
    else n_pass++;
  endtask

  task automatic test_abort;
    int c0;
    ev_t e;
    periodo = 4'd5; repeticoes = 4'd4;
    @(negedge CLK); iniciar = 1'b1; c0 = cyc + 1;
    e.cyc = c0 + 5; e.kind = 3'b001; e.rest = 5'd4; sb.push_back(e);
    e.cyc = c0 + 8; e.kind = 3'b100; e.rest = 5'd0; sb.push_back(e);
    @(negedge CLK); iniciar = 1'b0;
    clr_low = 0; ld_log.delete();
    sb_drain(7, 1'b0);
    parar = 1'b1;
    sb_drain(1, 1'b0);
    parar = 1'b0;
    sb_drain(30, 1'b0);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL abort_events got %0d pending required 0", sb.size());
    else n_pass++;
    n_checks++;
    if ({clr_low, ld_log.size(), 29'd0, estado} !== {32'd1, 32'd1, 32'd0})
      $display("FAIL abort_summary got clr_low=%0d ticks=%0d estado=%0d required 1 1 0",
               clr_low, ld_log.size(), estado);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c0;
    periodo = 4'd2; repeticoes = 4'd2;
    @(negedge CLK); iniciar = 1'b1; c0 = cyc + 1;
    push_run(c0, 2, 2);
    push_run(c0 + 7, 2, 2);
    sb_drain(40, 1'b1);
    iniciar = 1'b0;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL b2b_events got %0d pending required 0", sb.size());
    else n_pass++;
    sb_drain(2, 1'b0);
    n_checks++;
    if (estado !== 3'd0) $display("FAIL b2b_idle got estado=%0d required 0", estado);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    periodo = 4'd5; repeticoes = 4'd4;
    @(negedge CLK); iniciar = 1'b1;
    @(negedge CLK); iniciar = 1'b0;
    sb_drain(3, 1'b0);
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({estado, restantes, cnt_clr_n, cnt_ld_n, cnt_enp, cnt_ent, tick, ocupado, pronto, abortado}
        !== {3'd0, 5'd0, 8'b0100_0000})
      $display("FAIL async_reset got estado=%0d rest=%0d ctl=%b required 0 0 01000000", estado, restantes,
               {cnt_clr_n, cnt_ld_n, cnt_enp, cnt_ent, tick, ocupado, pronto, abortado});
    else n_pass++;
    @(negedge CLK); RESET = 1'b0;
    sb_drain(25, 1'b0);
    n_checks++;
    if ({estado, restantes} !== {3'd0, 5'd0})
      $display("FAIL reset_mid_idle got estado=%0d rest=%0d required 0 0", estado, restantes);
    else n_pass++;
  endtask

`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
  task automatic test_pausa;
    int c0;
    periodo = 4'd4; repeticoes = 4'd1;
    @(negedge CLK); iniciar = 1'b1; c0 = cyc + 1;
    push_run(c0, 4, 1);
    sb[0].cyc = c0 + 7;
    sb[1].cyc = c0 + 8;
    @(negedge CLK); iniciar = 1'b0;
    sb_drain(1, 1'b0);
    pausar = 1'b1;
    sb_drain(3, 1'b0);
    n_checks++;
    if ({estado, restantes, cnt_enp, cnt_ent} !== {3'd2, 5'd1, 2'b00})
      $display("FAIL paused got estado=%0d rest=%0d en=%b%b required 2 1 00", estado, restantes, cnt_enp, cnt_ent);
    else n_pass++;
    pausar = 1'b0;
    sb_drain(20, 1'b1);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL pausa_events got %0d pending required 0", sb.size());
    else n_pass++;
    @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_normal(4, 3, 4'd12);
    test_normal(0, 1, 4'd0);
    test_normal(1, 2, 4'd15);
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
    test_pausa();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_temporizador.md
CONTROLE_TEMPORIZADOR -- requirements
Module: controle_temporizador

Interface
REQ-001 Parameters: none.
REQ-002 Clock: CLK, input, 1 bit; all state changes on its rising edge.
REQ-003 Reset: RESET, input, 1 bit; asynchronous, active-high.
REQ-004 Port iniciar, input, 1: start request, level, sampled only in IDLE.
REQ-005 Port parar, input, 1: abort request, level.
REQ-006 Port periodo, input, 4: cycles per tick, 1..15; 0 means 16.
REQ-007 Port repeticoes, input, 4: ticks per run, 1..15; 0 means 16.
REQ-008 Port cnt_rco, input, 1: ripple carry from the external counter.
REQ-009 Port cnt_clr_n, output, 1: external counter sync clear, active-low.
REQ-010 Port cnt_ld_n, output, 1: external counter sync load, active-low.
REQ-011 Port cnt_enp / cnt_ent, output, 1 each: external counter enables.
REQ-012 Port cnt_d, output, 4: external counter load value.
REQ-013 Port tick, output, 1: one-cycle pulse per completed period.
REQ-014 Port ocupado, output, 1: high in CARREGA and CONTA.
REQ-015 Port pronto, output, 1: one-cycle pulse on normal run completion.
REQ-016 Port abortado, output, 1: one-cycle pulse on abort.
REQ-017 Port restantes, output, 5: ticks still to issue, 0..16.
REQ-018 Port estado, output, 3: state encoding (IDLE=0, CARREGA=1, CONTA=2, FIM=3, ABORTA=4).

Function
REQ-019 Drives one external 4-bit synchronous up-counter (clear > load > count priority, RCO = ENT & Q==15).
REQ-020 IDLE: cnt_clr_n=1, cnt_ld_n=1, cnt_enp=cnt_ent=0; iniciar=1 -> CARREGA; periodo and repeticoes latched on that edge.
REQ-021 cnt_d = (16 - P) mod 16 at all times, from latched P; for P=16, cnt_d=0.
REQ-022 CARREGA: cnt_ld_n=0 for exactly one cycle; restantes = R; next state CONTA.
REQ-023 CONTA: cnt_enp=cnt_ent=1; cnt_rco is qualified by state and ignored outside CONTA.
REQ-024 CONTA with cnt_rco=1: tick=1 combinationally; restantes decrements on that edge.
REQ-025 CONTA, cnt_rco=1, restantes>1: cnt_ld_n=0 in the same cycle; period is exactly P cycles, with no dead cycle.
REQ-026 CONTA, cnt_rco=1, restantes==1: next state FIM; cnt_ld_n stays 1.
REQ-027 FIM: cnt_clr_n=0, cnt_enp=cnt_ent=0, pronto=1; next state IDLE.
REQ-028 parar=1 in CARREGA or CONTA: next state ABORTA; parar has priority over cnt_rco; no tick in that cycle.
REQ-029 ABORTA: cnt_clr_n=0, abortado=1, restantes cleared; next state IDLE.
REQ-030 parar in IDLE or FIM: ignored.
REQ-031 iniciar held high: a new run starts from IDLE, giving back-to-back runs 2 cycles apart.
REQ-032 First tick occurs P cycles after entering CONTA.
REQ-033 Total run length from the iniciar sample edge is 1 + P*R cycles to the pronto cycle.

Reset
REQ-034 RESET=1: state IDLE, latched P/R=0, restantes=0 immediately.
REQ-035 During RESET: tick, pronto, abortado, ocupado = 0; cnt_clr_n=0, cnt_ld_n=1, cnt_enp=cnt_ent=0.
REQ-036 Reset mid-run: the run is discarded; no pronto or abortado pulse is produced.

Configuration
REQ-037 Macro CONTROLE_TEMPORIZADOR_PAUSA_EN defined: adds input pausar (1 bit).
REQ-038 With the macro, pausar=1 in CONTA forces cnt_enp=cnt_ent=0 and masks tick and cnt_rco.
REQ-039 With the macro, the state and restantes are held while paused; parar still aborts.
REQ-040 Macro undefined: no pausar port; behaviour as REQ-019..033.

Verification
REQ-041 P=4, R=3, iniciar 1 cycle: ticks at CONTA-entry+4, +8, +12; pronto 1 cycle after the third tick; restantes 3->2->1->0.
REQ-042 P=0, R=1: cnt_d=0; single tick 16 cycles after CONTA entry; then pronto.
REQ-043 P=1, R=2: tick high 2 consecutive cycles; cnt_ld_n low in the first tick cycle only.
REQ-044 P=5, R=4, parar on the 7th CONTA cycle: abortado pulse; cnt_clr_n=0 one cycle; 1 tick total; never pronto.
REQ-045 RESET asserted mid-CONTA between edges: outputs reach reset values without a clock edge; IDLE after release.
REQ-046 With PAUSA_EN: P=4, R=1, pausar high for 3 cycles mid-count: tick delayed by exactly 3 cycles.
